// File: rtl/multadd_seq_ctrl_pkg.sv
// Shared constants for the sequential multiply-add controller: default width
// and the 2-bit FSM state encodings.
package multadd_seq_ctrl_pkg;

  localparam int MULTADD_WIDTH_DEF = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_ADD  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/multadd_shift_mul.sv
// Shift-add multiplier: latches x1/x2 on start, then adds one shifted partial
// product per step, LSB first. done flags the final iteration.
module multadd_shift_mul
  import multadd_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = MULTADD_WIDTH_DEF,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               step,
  input  logic [WIDTH-1:0]   x1,
  input  logic [WIDTH-1:0]   x2,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   x1_q;
  logic [WIDTH-1:0]   x2_q;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  // NOTE: every flop here is a plain register, so all of them get an async
  // clear; there is no memory array that would need to skip reset.
  // NOTE: sequential state uses <= so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x1_q <= '0;
      x2_q <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (start) begin
      x1_q <= x1;
      x2_q <= x2;
      acc  <= '0;
      cnt  <= '0;
    end else if (step) begin
      if (x2_q[cnt])
        acc <= acc + ({{WIDTH{1'b0}}, x1_q} << cnt);
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign done    = step && (cnt == CNT_W'(WIDTH - 1));
  assign product = acc;

endmodule

// File: rtl/multadd_seq_ctrl.sv
// Sequential y = x1*x2 + x3 controller with valid/ready on both sides.
// Define MULTADD_SATURATE_EN to clamp y to all-ones whenever ovf is set.
module multadd_seq_ctrl
  import multadd_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = MULTADD_WIDTH_DEF,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             ovf,
  output logic             busy
);

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [WIDTH-1:0]   x3_q;
  logic               accept;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH:0]   sum;
  logic               ovf_next;
  logic [WIDTH-1:0]   y_next;

  assign accept = (state == ST_IDLE) && in_valid;

  multadd_shift_mul #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept),
    .step    (state == ST_MUL),
    .x1      (x1),
    .x2      (x2),
    .done    (mul_done),
    .product (product)
  );

  // One extra bit keeps the carry out of the full 2*WIDTH product + addend.
  assign sum      = {1'b0, product} + {{(WIDTH + 1){1'b0}}, x3_q};
  assign ovf_next = |sum[2*WIDTH:WIDTH];

`ifdef MULTADD_SATURATE_EN
  assign y_next = ovf_next ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
  assign y_next = sum[WIDTH-1:0];
`endif

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid)  state_next = ST_MUL;
      ST_MUL:  if (mul_done)  state_next = ST_ADD;
      ST_ADD:                 state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      x3_q  <= '0;
      y     <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept)
        x3_q <= x3;
      if (state == ST_ADD) begin
        y   <= y_next;
        ovf <= ovf_next;
      end
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_multadd_seq_ctrl.sv
// Scoreboard bench for multadd_seq_ctrl: stimulus pushes model results into a
// queue, a negedge monitor pops and compares on every output handshake.
module tb_multadd_seq_ctrl;

  localparam int W  = 10;
  localparam int CW = 4;

  typedef struct packed {
    logic [W-1:0] y;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x1, x2, x3;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         ovf;
  logic         busy;

  res_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   results  = 0;
  int   acc_edge = 0;

  multadd_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: full-precision arithmetic, then wrap or clamp.
  function automatic res_t model(input int a, input int b, input int c);
    res_t   r;
    longint full;
    full  = longint'(a) * longint'(b) + longint'(c);
    r.ovf = (full >= (longint'(1) << W));
`ifdef MULTADD_SATURATE_EN
    r.y = r.ovf ? {W{1'b1}} : W'(full);
`else
    r.y = W'(full % (longint'(1) << W));
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      res_t e;
      results++;
      if (sb.size() == 0) check("unexpected result", 1, 0);
      else begin
        e = sb.pop_front();
        check("sb y", y, e.y);
        check("sb ovf", ovf, e.ovf);
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic issue(input int a, input int b, input int c, input bit push, input bit hold);
    int t = 0;
    x1 = W'(a); x2 = W'(b); x3 = W'(c);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) check("accept timeout", 0, 1);
    else begin
      if (push) sb.push_back(model(a, b, c));
      acc_edge = cyc + 1;
    end
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    int t = 0;
    @(negedge clk);
    while (!out_valid && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!out_valid) check("out_valid timeout", 0, 1);
    edges = cyc - acc_edge;
  endtask

  task automatic drain();
    int t = 0;
    @(negedge clk);
    while ((sb.size() != 0 || out_valid) && t < 300) begin
      t++;
      @(negedge clk);
    end
    if (t >= 300) check("drain timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, r0, prev;
    res_t e;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x1 = '0; x2 = '0; x3 = '0;

    #12;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst y", y, 0);
    check("rst ovf", ovf, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("post-rst in_ready", in_ready, 1);
    check("post-rst busy", busy, 0);

    // Basic op with latency.
    issue('h003, 'h005, 'h007, 1, 0);
    check("busy in MUL", busy, 1);
    wait_valid(lat);
    check("latency", lat, 11);
    check("basic y", y, 'h016);
    check("basic ovf", ovf, 0);
    drain();

    // Overflow cases.
    issue('h3FF, 'h3FF, 'h3FF, 1, 0);
    drain();
    issue('h020, 'h020, 'h000, 1, 0);
    drain();
    issue(0, 'h3FF, 'h123, 1, 0);
    drain();

    // Back-pressure.
    out_ready = 1'b0;
    e = model('h2B7, 'h1C9, 'h3E1);
    issue('h2B7, 'h1C9, 'h3E1, 1, 0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp out_valid", out_valid, 1);
      check("bp in_ready", in_ready, 0);
      check("bp y", y, e.y);
      check("bp ovf", ovf, e.ovf);
    end
    r0 = results;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp out_valid dropped", out_valid, 0);
    check("bp one result", results, r0 + 1);
    out_ready = 1'b1;

    // in_valid during MUL is ignored.
    r0 = results;
    issue('h011, 'h022, 'h033, 1, 0);
    repeat (2) @(posedge clk); #1;
    x1 = 'h3AA; x2 = 'h155; x3 = 'h0FF; in_valid = 1'b1;
    @(negedge clk);
    check("mul in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    repeat (15) @(posedge clk); #1;
    check("ignored single result", results, r0 + 1);

    // Reset mid-MUL discards the operation.
    r0 = results;
    issue('h123, 'h0AB, 'h055, 0, 0);
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid-rst out_valid", out_valid, 0);
    check("mid-rst in_ready", in_ready, 1);
    check("mid-rst y", y, 0);
    check("mid-rst busy", busy, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    issue('h000, 'h2AA, 'h155, 1, 0);
    wait_valid(lat);
    check("after-rst y", y, 'h155);
    drain();
    check("mid-rst no stray result", results, r0 + 1);

    // Back-to-back random ops with in_valid and out_ready held high.
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      issue(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
            int'($urandom_range(0, 1023)), 1, 1);
      if (i > 0) check("accept spacing", acc_edge - prev, W + 3);
      prev = acc_edge;
    end
    in_valid = 1'b0;
    drain();

    check("queue empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
